md_unit_param: RTL

- Parametrised successor to the fixed 32-bit multiply/divide unit in the CPU execute stage.
- Owns the HI/LO pair and supports MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB plus MTHI/MTLO.
- Multiplies complete after a parameterised fixed latency.
- Divides use an iterative restoring divider (one quotient bit per cycle) driven by an explicit FSM.
- `busy` stalls the pipeline exactly as the current unit does.

---
 rtl/md_unit_param.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit owning HI/LO: fixed-latency multiply-class ops, restoring divider.
// Optional exception-flush input `cancel` is added when MD_UNIT_CANCEL_EN is defined.
module md_unit_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             Clk,
  input  logic             Reset,
`ifdef MD_UNIT_CANCEL_EN
  input  logic             cancel,
`endif
  input  logic             start,
  input  logic [2:0]       MDOp,
  input  logic [1:0]       MTOp,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  output logic             busy,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int W       = WIDTH;
  localparam int DIV_LAT = WIDTH + 2;
  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MADD  = 3'b101;
  localparam logic [2:0] OP_MADDU = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [2:0] {IDLE, MUL, DSETUP, DITER, DFIX} state_t;
  state_t state, state_n;

  logic          cancel_w;
  logic [W-1:0]  op_a, op_b, quo, rem, dvs;
  logic [2:0]    op_q;
  logic [2*W-1:0] acc;
  logic          q_neg, r_neg, dz;
  logic [CW-1:0] cnt;
  logic          accept_mul, accept_div, mul_done, div_done, mt_hi, mt_lo;

`ifdef MD_UNIT_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  assign busy = (state != IDLE);

  // Handshake: start is accepted only in IDLE; busy rises the following cycle and
  // falls on the edge that writes HI/LO. start or MTOp seen while busy is dropped.
  always_comb begin
    state_n    = state;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    mul_done   = 1'b0;
    div_done   = 1'b0;
    mt_hi      = 1'b0;
    mt_lo      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (MDOp == OP_DIV || MDOp == OP_DIVU) begin
            accept_div = 1'b1;
            state_n    = DSETUP;
          end else if (MDOp != 3'b000) begin
            accept_mul = 1'b1;
            state_n    = MUL;
          end
        end else begin
          mt_hi = (MTOp == 2'b01);
          mt_lo = (MTOp == 2'b10);
        end
      end
      MUL: begin
        if (cnt == CW'(MUL_LAT - 1)) begin
          mul_done = 1'b1;
          state_n  = IDLE;
        end
      end
      DSETUP: state_n = DITER;
      DITER:  if (cnt == CW'(WIDTH - 1)) state_n = DFIX;
      DFIX: begin
        div_done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A flush overrides everything, including a completing edge.
    if (cancel_w) begin
      state_n    = IDLE;
      accept_mul = 1'b0;
      accept_div = 1'b0;
      mul_done   = 1'b0;
      div_done   = 1'b0;
      mt_hi      = 1'b0;
      mt_lo      = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  // Multiply results, all modulo 2^(2W).
  logic [2*W-1:0] ext_as, ext_bs, ext_au, ext_bu, prod_s, prod_u, mul_res;
  assign ext_as = {{W{op_a[W-1]}}, op_a};
  assign ext_bs = {{W{op_b[W-1]}}, op_b};
  assign ext_au = {{W{1'b0}}, op_a};
  assign ext_bu = {{W{1'b0}}, op_b};
  assign prod_s = ext_as * ext_bs;
  assign prod_u = ext_au * ext_bu;

  always_comb begin
    mul_res = prod_s;
    case (op_q)
      OP_MULTU: mul_res = prod_u;
      OP_MADD:  mul_res = acc + prod_s;
      OP_MADDU: mul_res = acc + prod_u;
      OP_MSUB:  mul_res = acc - prod_s;
      default:  mul_res = prod_s;
    endcase
  end

  // Divider setup and one restoring step.
  logic         a_neg, b_neg;
  logic [W:0]   shifted, diff;
  assign a_neg   = (op_q == OP_DIV) && op_a[W-1];
  assign b_neg   = (op_q == OP_DIV) && op_b[W-1];
  assign shifted = {rem, quo[W-1]};
  assign diff    = shifted - {1'b0, dvs};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_a  <= '0;
      op_b  <= '0;
      op_q  <= '0;
      acc   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz    <= 1'b0;
      cnt   <= '0;
      Hi    <= '0;
      Lo    <= '0;
    end else begin
      if (accept_mul || accept_div) begin
        op_a <= A1;
        op_b <= A2;
        op_q <= MDOp;
        acc  <= {Hi, Lo};
        cnt  <= '0;
      end
      case (state)
        MUL: cnt <= cnt + 1'b1;
        DSETUP: begin
          quo   <= a_neg ? -op_a : op_a;
          dvs   <= b_neg ? -op_b : op_b;
          rem   <= '0;
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          dz    <= (op_b == '0);
          cnt   <= '0;
        end
        DITER: begin
          cnt <= cnt + 1'b1;
          if (!diff[W]) begin
            rem <= diff[W-1:0];
            quo <= {quo[W-2:0], 1'b1};
          end else begin
            rem <= shifted[W-1:0];
            quo <= {quo[W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
      if (mul_done) {Hi, Lo} <= mul_res;
      // The most-negative / -1 case wraps naturally through the sign fix-up.
      if (div_done && !dz) begin
        Lo <= q_neg ? -quo : quo;
        Hi <= r_neg ? -rem : rem;
      end
      if (mt_hi) Hi <= A1;
      if (mt_lo) Lo <= A1;
    end
  end

  logic unused_div_lat;
  assign unused_div_lat = (DIV_LAT == 0);
endmodule
